// File: rtl/multicycle_control32.sv
// Multi-cycle main control for the Minisys 32-bit CPU: decodes the IR fields and
// sequences FETCH/DECODE/EXEC/MEM/WB with memory ready timeouts and MDU stalls.
module multicycle_control32 #(
  parameter int EN_MDU      = 1,
  parameter int MDU_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function_opcode,
  input  logic       Zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       dmem_read,
  output logic       dmem_write,
  output logic       RegDST,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic       nBranch,
  output logic       Jmp,
  output logic       Jal,
  output logic       Jrn,
  output logic       I_format,
  output logic       Sftmd,
  output logic [1:0] ALUOp,
  output logic       mdu_start,
  output logic       illegal_instr,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_MDU    = 3'd6
  } state_t;

  localparam logic       MDU_ON   = (EN_MDU != 0);
  localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES);
  localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic [7:0] mdu_cnt;
  logic       wait_inc;
  logic       wait_clr;
  logic       mdu_load;

  logic is_r;
  logic is_jr;
  logic is_shift;
  logic is_mdu;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_bne;
  logic is_j;
  logic is_jal;
  logic is_ifmt;
  logic is_legal;
  logic steer_on;

  assign is_r     = (Opcode == 6'b000000);
  assign is_jr    = is_r && (Function_opcode == 6'b001000);
  assign is_shift = is_r && (Function_opcode[5:3] == 3'b000);
  assign is_mdu   = is_r && (Function_opcode[5:2] == 4'b0110);
  assign is_lw    = (Opcode == 6'b100011);
  assign is_sw    = (Opcode == 6'b101011);
  assign is_beq   = (Opcode == 6'b000100);
  assign is_bne   = (Opcode == 6'b000101);
  assign is_j     = (Opcode == 6'b000010);
  assign is_jal   = (Opcode == 6'b000011);
  assign is_ifmt  = (Opcode[5:3] == 3'b001);
  assign is_legal = (is_r && (!is_mdu || MDU_ON)) || is_ifmt || is_lw || is_sw ||
                    is_beq || is_bne || is_j || is_jal;

  // ALU/register-file steering is only meaningful while the instruction executes
  assign steer_on = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
  assign RegDST   = steer_on && is_r;
  assign ALUSrc   = steer_on && (is_ifmt || is_lw || is_sw);
  assign Sftmd    = steer_on && is_shift;
  assign I_format = steer_on && is_ifmt;
  assign ALUOp    = steer_on ? {is_r || is_ifmt, is_beq || is_bne} : 2'b00;
  assign state    = state_q;

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    Branch        = 1'b0;
    nBranch       = 1'b0;
    Jmp           = 1'b0;
    Jal           = 1'b0;
    Jrn           = 1'b0;
    mdu_start     = 1'b0;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;
    mdu_load      = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (wait_cnt >= WAIT_LIM) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          illegal_instr = 1'b1;
          state_d       = S_FETCH;
        end else if (is_j) begin
          Jmp     = 1'b1;
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else if (is_jr) begin
          Jrn     = 1'b1;
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else if (is_jal) begin
          Jal     = 1'b1;
          PCWrite = 1'b1;
          state_d = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          Branch  = 1'b1;
          PCWrite = Zero;
          state_d = S_FETCH;
        end else if (is_bne) begin
          nBranch = 1'b1;
          PCWrite = !Zero;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_mdu && MDU_ON) begin
          mdu_start = 1'b1;
          mdu_load  = 1'b1;
          state_d   = S_MDU;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_read  = is_lw;
        dmem_write = is_sw;
        if (dmem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (wait_cnt >= WAIT_LIM) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        Jal      = is_jal;
        MemtoReg = is_lw;
        state_d  = S_FETCH;
      end
      S_MDU: begin
        if (mdu_cnt <= 8'd1) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout re-enters FETCH, so it must restart the wait count like any entry
    wait_clr = (state_d != state_q) || bus_err;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_cnt <= '0;
      mdu_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 8'd1;
      if (mdu_load)                              mdu_cnt <= MDU_LOAD;
      else if (state_q == S_MDU && mdu_cnt != 0) mdu_cnt <= mdu_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_control32.sv
// Bench for multicycle_control32: per-instruction expected cycle traces built from
// the instruction timing rules, driven with randomized instructions and ready delays.
module tb_multicycle_control32;

  localparam int TO    = 8;
  localparam int MDU_N = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_MDU = 3'd6;

  typedef struct packed {
    logic imem_req, ir_write, pc_write, dmem_read, dmem_write;
    logic reg_dst, alu_src, mem_to_reg, reg_write, branch, nbranch;
    logic jmp, jal, jrn, i_format, sftmd;
    logic [1:0] alu_op;
    logic mdu_start, illegal, bus_err;
    logic [2:0] state;
  } out_t;

  typedef struct {
    logic ir;
    logic dr;
    out_t exp;
  } cyc_t;

  typedef enum int {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_MDU, K_ILL} kind_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;

  logic imem_req, IRWrite, PCWrite, dmem_read, dmem_write;
  logic RegDST, ALUSrc, MemtoReg, RegWrite, Branch, nBranch, Jmp, Jal, Jrn, I_format, Sftmd;
  logic [1:0] ALUOp;
  logic mdu_start, illegal_instr, bus_err;
  logic [2:0] state;

  logic [5:0] opcode2 = 6'd0;
  logic [5:0] funct2 = 6'b011000;
  logic zero2 = 1'b0, ready2 = 1'b1;
  logic ireq2, irw2, pcw2, drd2, dwr2, rdst2, asrc2, m2r2, rw2, br2, nbr2, jmp2, jal2, jrn2;
  logic ifmt2, sft2, mdus2, ill2, berr2;
  logic [1:0] aop2;
  logic [2:0] state2;

  int errors = 0;
  int checks = 0;
  cyc_t trace[$];
  out_t obs;

  always #5 clock = ~clock;

  assign obs = {imem_req, IRWrite, PCWrite, dmem_read, dmem_write,
                RegDST, ALUSrc, MemtoReg, RegWrite, Branch, nBranch,
                Jmp, Jal, Jrn, I_format, Sftmd, ALUOp,
                mdu_start, illegal_instr, bus_err, state};

  multicycle_control32 #(.EN_MDU(1), .MDU_CYCLES(MDU_N), .MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .Opcode(opcode), .Function_opcode(funct), .Zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .RegDST(RegDST), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn),
    .I_format(I_format), .Sftmd(Sftmd), .ALUOp(ALUOp),
    .mdu_start(mdu_start), .illegal_instr(illegal_instr), .bus_err(bus_err), .state(state)
  );

  multicycle_control32 #(.EN_MDU(0), .MDU_CYCLES(MDU_N), .MEM_TIMEOUT(TO)) dut_nomdu (
    .clock(clock), .reset(reset), .Opcode(opcode2), .Function_opcode(funct2), .Zero(zero2),
    .imem_ready(ready2), .dmem_ready(ready2),
    .imem_req(ireq2), .IRWrite(irw2), .PCWrite(pcw2),
    .dmem_read(drd2), .dmem_write(dwr2),
    .RegDST(rdst2), .ALUSrc(asrc2), .MemtoReg(m2r2), .RegWrite(rw2),
    .Branch(br2), .nBranch(nbr2), .Jmp(jmp2), .Jal(jal2), .Jrn(jrn2),
    .I_format(ifmt2), .Sftmd(sft2), .ALUOp(aop2),
    .mdu_start(mdus2), .illegal_instr(ill2), .bus_err(berr2), .state(state2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 6'b001000) return K_JR;
      if (fn[5:2] == 4'b0110) return K_MDU;
      return K_ALU;
    end
    if (op[5:3] == 3'b001) return K_ALU;
    case (op)
      6'd35:   return K_LW;
      6'd43:   return K_SW;
      6'd4:    return K_BEQ;
      6'd5:    return K_BNE;
      6'd2:    return K_J;
      6'd3:    return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic out_t blank(input logic [2:0] st);
    out_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic out_t with_steer(input out_t oi, input logic [5:0] op, input logic [5:0] fn);
    out_t o;
    logic r, ifm, mem, br;
    o   = oi;
    r   = (op == 6'd0);
    ifm = (op[5:3] == 3'b001);
    mem = (op == 6'd35) || (op == 6'd43);
    br  = (op == 6'd4) || (op == 6'd5);
    o.reg_dst  = r;
    o.alu_src  = ifm || mem;
    o.sftmd    = r && (fn[5:3] == 3'b000);
    o.i_format = ifm;
    o.alu_op   = {r || ifm, br};
    return o;
  endfunction

  // ready code 2 means "don't care": the bench drives a random value
  task automatic push(input out_t o, input int ir, input int dr);
    cyc_t c;
    c.exp = o;
    c.ir  = (ir == 2) ? 1'($urandom_range(0, 1)) : ir[0];
    c.dr  = (dr == 2) ? 1'($urandom_range(0, 1)) : dr[0];
    trace.push_back(c);
  endtask

  // li: fetch ready-low cycles (0..TO); ld: memory ready-low cycles, > TO means timeout
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int li, input int ld);
    out_t o;
    kind_t k;
    trace.delete();
    k = classify(op, fn);
    o = blank(ST_FETCH);
    o.imem_req = 1'b1;
    for (int i = 0; i < li; i++) push(o, 0, 2);
    o.ir_write = 1'b1;
    o.pc_write = 1'b1;
    push(o, 1, 2);
    o = blank(ST_DECODE);
    case (k)
      K_ILL: begin o.illegal = 1'b1; push(o, 2, 2); return; end
      K_J:   begin o.jmp = 1'b1; o.pc_write = 1'b1; push(o, 2, 2); return; end
      K_JR:  begin o.jrn = 1'b1; o.pc_write = 1'b1; push(o, 2, 2); return; end
      K_JAL: begin
        o.jal = 1'b1; o.pc_write = 1'b1; push(o, 2, 2);
        o = with_steer(blank(ST_WB), op, fn);
        o.jal = 1'b1; o.reg_write = 1'b1; push(o, 2, 2);
        return;
      end
      default: push(o, 2, 2);
    endcase
    o = with_steer(blank(ST_EXEC), op, fn);
    case (k)
      K_BEQ: begin o.branch = 1'b1; o.pc_write = z; push(o, 2, 2); end
      K_BNE: begin o.nbranch = 1'b1; o.pc_write = !z; push(o, 2, 2); end
      K_MDU: begin
        o.mdu_start = 1'b1; push(o, 2, 2);
        for (int i = 0; i < MDU_N; i++) push(blank(ST_MDU), 2, 2);
      end
      K_ALU: begin
        push(o, 2, 2);
        o = with_steer(blank(ST_WB), op, fn);
        o.reg_write = 1'b1; push(o, 2, 2);
      end
      default: begin
        push(o, 2, 2);
        o = with_steer(blank(ST_MEM), op, fn);
        o.dmem_read  = (k == K_LW);
        o.dmem_write = (k == K_SW);
        if (ld > TO) begin
          for (int i = 0; i < TO; i++) push(o, 2, 0);
          o.bus_err = 1'b1;
          push(o, 2, 0);
        end else begin
          for (int i = 0; i < ld; i++) push(o, 2, 0);
          push(o, 2, 1);
          if (k == K_LW) begin
            o = with_steer(blank(ST_WB), op, fn);
            o.reg_write = 1'b1; o.mem_to_reg = 1'b1; push(o, 2, 2);
          end
        end
      end
    endcase
  endtask

  task automatic build_fetch_timeout();
    out_t o;
    trace.delete();
    o = blank(ST_FETCH);
    o.imem_req = 1'b1;
    for (int i = 0; i < TO; i++) push(o, 0, 2);
    o.bus_err = 1'b1;
    push(o, 0, 2);
  endtask

  task automatic run_trace(input string tag, input int n);
    for (int i = 0; i < trace.size(); i++) begin
      if (n >= 0 && i >= n) break;
      imem_ready = trace[i].ir;
      dmem_ready = trace[i].dr;
      @(negedge clock);
      check_eq($sformatf("%s[%0d]", tag, i), {8'd0, obs}, {8'd0, trace[i].exp});
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int li, input int ld);
    opcode = op;
    funct  = fn;
    zero   = z;
    build(op, fn, z, li, ld);
    run_trace(tag, -1);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    trace.delete();
    push(blank(ST_IDLE), 2, 2);
    run_trace("idle", -1);
  endtask

  int seq2[6] = '{0, 1, 2, 1, 2, 1};

  // Without the MDU every mult fetch must end in an illegal_instr pulse in DECODE
  initial begin
    logic [2:0] s;
    @(posedge reset);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      s = 3'(seq2[i]);
      check_eq("nomdu", {25'd0, state2, ill2, mdus2, rw2, ireq2},
               {25'd0, s, s == 3'd2, 1'b0, 1'b0, s == 3'd1});
    end
  end

  initial begin
    logic [5:0] op, fn;
    int li, ld, r;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    opcode     = 6'd35;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("reset", {8'd0, obs}, 32'd0);
    release_reset();

    do_instr("add",     6'd0,  6'h20, 1'b0, 0, 0);
    do_instr("lw_d3",   6'd35, 6'h11, 1'b0, 0, 3);
    do_instr("beq_z1",  6'd4,  6'h00, 1'b1, 0, 0);
    do_instr("bne_z1",  6'd5,  6'h00, 1'b1, 0, 0);
    do_instr("beq_z0",  6'd4,  6'h00, 1'b0, 1, 0);
    do_instr("mult",    6'd0,  6'h18, 1'b0, 0, 0);
    do_instr("sw_to",   6'd43, 6'h00, 1'b0, 0, TO + 1);
    do_instr("sw_edge", 6'd43, 6'h00, 1'b0, 0, TO);
    do_instr("lw_to",   6'd35, 6'h00, 1'b0, 2, TO + 1);
    do_instr("addi_fe", 6'd8,  6'h00, 1'b0, TO, 0);
    build_fetch_timeout();
    run_trace("f_to", -1);
    do_instr("j",       6'd2,  6'h00, 1'b0, 0, 0);
    do_instr("jr",      6'd0,  6'h08, 1'b0, 0, 0);
    do_instr("jal",     6'd3,  6'h00, 1'b0, 1, 0);
    do_instr("sll",     6'd0,  6'h00, 1'b0, 0, 0);
    do_instr("ill",     6'h3f, 6'h00, 1'b0, 0, 0);

    // Abandon a store in its second MEM cycle
    opcode = 6'd43; funct = 6'd0; zero = 1'b0;
    build(6'd43, 6'd0, 1'b0, 0, 6);
    run_trace("sw_rst", 4);
    dmem_ready = 1'b0;
    #2;
    check_eq("sw_rst_mem", {8'd0, obs}, {8'd0, trace[4].exp});
    reset = 1'b0;
    #1;
    check_eq("rst_async", {8'd0, obs}, 32'd0);
    @(negedge clock);
    check_eq("rst_hold", {8'd0, obs}, 32'd0);
    release_reset();
    do_instr("post_rst", 6'd0, 6'h21, 1'b0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        build_fetch_timeout();
        run_trace("rnd_fto", -1);
      end
      op = 6'($urandom_range(0, 63));
      fn = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 9))
          0: begin op = 6'd0; fn = 6'h20; end
          1: begin op = 6'd0; fn = {3'b000, 3'($urandom_range(0, 7))}; end
          2: begin op = 6'd0; fn = 6'h08; end
          3: begin op = 6'd0; fn = {4'b0110, 2'($urandom_range(0, 3))}; end
          4: op = {3'b001, 3'($urandom_range(0, 7))};
          5: op = 6'd35;
          6: op = 6'd43;
          7: op = 6'd4 + 6'($urandom_range(0, 1));
          8: op = 6'd2 + 6'($urandom_range(0, 1));
          default: op = 6'd0;
        endcase
      end
      r = $urandom_range(0, 19);
      if (r < 12)      li = 0;
      else if (r < 18) li = $urandom_range(1, 3);
      else             li = TO;
      r = $urandom_range(0, 19);
      if (r < 10)      ld = 0;
      else if (r < 16) ld = $urandom_range(1, 4);
      else if (r < 18) ld = TO;
      else             ld = TO + 1;
      do_instr("rnd", op, fn, 1'($urandom_range(0, 1)), li, ld);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control32.md
# multicycle_control32

Multi-cycle main control unit for the Minisys 32-bit CPU. It keeps the single-cycle control unit's instruction decode (same opcode/funct classes and the same control outputs) but sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It adds ready/valid memory handshakes with a timeout, an optional iterative multiply/divide unit (MDU) stall, and illegal-instruction detection. It sits between the instruction register and the shared datapath (ifetch, register file, ALU, memory/IO bus).

## Interface
- `EN_MDU`, 1: 1 = mult/multu/div/divu (funct 0110xx) are legal and use the MDU; 0 = they are illegal.
- `MDU_CYCLES`, 32: MDU busy cycles (1..255).
- `MEM_TIMEOUT`, 255: maximum wait cycles for any memory ready (1..255).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `Opcode` in 6: IR[31:26]; valid from DECODE onward.
- `Function_opcode` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag, sampled in EXEC.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory/IO access complete.
- `imem_req` out 1: fetch request.
- `IRWrite` out 1: load IR.
- `PCWrite` out 1: update PC.
- `dmem_read` out 1: data memory read request.
- `dmem_write` out 1: data memory write request.
- Decode outputs, 1 bit each: `RegDST`, `ALUSrc`, `MemtoReg`, `RegWrite`, `Branch`, `nBranch`, `Jmp`, `Jal`, `Jrn`, `I_format`, `Sftmd`.
- `ALUOp` out 2: ALU operation class.
- `mdu_start` out 1: one-cycle MDU start pulse.
- `illegal_instr` out 1: one-cycle pulse.
- `bus_err` out 1: one-cycle pulse on memory timeout.
- `state` out 3: current state, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, MDU=6.
- Decode classes:
  - R = opcode 000000.
  - jr = R with funct 001000.
  - shift = R with funct 000xxx.
  - lw = 100011; sw = 101011; beq = 000100; bne = 000101; j = 000010; jal = 000011.
  - I_format = opcode[5:3] 001.
  - Anything else is illegal.
- Decode outputs are combinational from `Opcode`/`Function_opcode`, gated so they are active only in the states listed below:
  - `RegDST` = R; `ALUSrc` = I_format|lw|sw; `MemtoReg` = lw; `Sftmd` = shift; `I_format` = I_format.
  - `ALUOp` = {R|I_format, beq|bne}.
- IDLE: all outputs 0; go to FETCH unconditionally.
- FETCH: `imem_req`=1. On `imem_ready`: pulse `IRWrite` and `PCWrite` (PC+4), go to DECODE.
- DECODE:
  - illegal: pulse `illegal_instr`, go to FETCH; no register or memory write.
  - j: `Jmp`=1, `PCWrite`=1, go to FETCH.
  - jr: `Jrn`=1, `PCWrite`=1, go to FETCH.
  - jal: `Jal`=1, `PCWrite`=1, go to WB.
  - all others: go to EXEC.
- EXEC:
  - beq/bne: `Branch`/`nBranch`=1; `PCWrite`=1 only if the condition holds (beq&Zero or bne&!Zero); go to FETCH.
  - lw/sw: go to MEM.
  - MDU funct with EN_MDU: pulse `mdu_start`, load the counter with MDU_CYCLES, go to MDU.
  - else: go to WB.
- MEM: `dmem_read`=lw or `dmem_write`=sw, held until `dmem_ready`.
  - lw then goes to WB.
  - sw then goes to FETCH.
- WB: `RegWrite`=1 for one cycle (with `Jal` for jal, `MemtoReg` for lw); go to FETCH.
- MDU: counter decrements each cycle; when it reaches 1, go to FETCH. No `RegWrite`; HI/LO is owned by the MDU.
- Timeout:
  - An 8-bit wait counter clears on entering FETCH or MEM and increments each cycle ready is low.
  - When it reaches MEM_TIMEOUT with ready still low: pulse `bus_err`, drop the request, go to FETCH. No `IRWrite`/`RegWrite`; PC is unchanged in MEM (PC was already advanced in FETCH).
- Ready in the same cycle as the timeout: ready wins; no `bus_err`.

## Timing
- Reset: `state`=IDLE, counters 0, every output 0 while `reset` is low.
- First `imem_req` is asserted in the second cycle after `reset` deasserts (IDLE, then FETCH).
- Cycle counts with ready returned in the first request cycle:
  - R/I ALU: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne: 3.
  - j/jr: 2.
  - jal: 3.
  - mult/div: 3+MDU_CYCLES.
- Each ready-low cycle adds one.
- Requests (`imem_req`, `dmem_read`, `dmem_write`) stay high and stable until the ready edge; they deassert the cycle after.
- Pulses (`IRWrite`, `PCWrite`, `RegWrite`, `mdu_start`, `illegal_instr`, `bus_err`) last exactly one cycle.
- `reset` asserted mid-instruction: outputs go to 0 immediately (asynchronous); the instruction is abandoned and nothing is written afterward.

## Test plan
- Reset release, imem_ready=1 constantly, IR=add $1,$2,$3 (op 0, funct 100000) -> `state` 0,1,2,3,5,1; `RegWrite`=1 in cycle 4 only; `RegDST`=1; `ALUOp`=2'b10.
- lw with `dmem_ready` delayed 3 cycles -> `dmem_read` high 4 cycles; `RegWrite` and `MemtoReg`=1 in the following cycle; total 8 cycles.
- beq with Zero=1, then bne with Zero=1 -> `PCWrite` pulses in EXEC for beq only; both return to FETCH after 3 cycles.
- mult with EN_MDU=1, MDU_CYCLES=4 -> `mdu_start` pulse in EXEC, 4 MDU cycles, no `RegWrite`; with EN_MDU=0 -> `illegal_instr` pulse in DECODE.
- MEM_TIMEOUT=8, `dmem_ready` held 0 on sw -> `bus_err` pulse after 8 wait cycles, `dmem_write` drops, next state FETCH; repeat with ready rising in that same cycle -> no `bus_err`.
- `reset` pulled low during MEM of sw -> `dmem_write`=0 the same cycle; after release, `state` goes IDLE then FETCH.
